// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - RAM port bundle between the BIST initiator and the RAM
// Signals:
//   ram_en   : RAM enable (driven by master)
//   ram_we   : byte write enables, 2'b00 (read) or 2'b11 (write)
//   ram_addr : RAM word address
//   ram_din  : RAM write data
//   ram_dout : RAM read data, valid the cycle after a read access (driven by slave)
interface ram_bist_if #(
    parameter int ADDR_MSB = 9
) ();
    logic              ram_en;
    logic [1:0]        ram_we;
    logic [ADDR_MSB:0] ram_addr;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    modport master (
        output ram_en,
        output ram_we,
        output ram_addr,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_en,
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - March C- memory BIST initiator for one RAM port
// Ports:
//   mclk, reset_n   : clock, asynchronous active-low reset
//   bist_start      : start request, sampled in IDLE only
//   bist_busy       : test running
//   bist_done       : one-cycle pulse at test completion
//   bist_fail       : sticky mismatch flag, cleared on accepted start
//   bist_fail_addr  : word address of the first mismatch
//   bist_fail_data  : read data of the first mismatch
//   ram             : RAM port (ram_bist_if master modport)
// Build option: RAM_BIST_CHECKERBOARD_EN adds a second pass with background 16'h5555.
module ram_bist #(
    parameter int ADDR_MSB = 9,
    parameter int MEM_SIZE = 2048
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_MSB:0] bist_fail_addr,
    output logic [15:0]       bist_fail_data,
    ram_bist_if.master        ram
);
    localparam int              AW     = ADDR_MSB + 1;
    localparam int              NWORDS = MEM_SIZE / 2;
    localparam logic [AW-1:0]   LAST   = AW'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0_W,
        S_M_R,
        S_M_W,
        S_M5_R,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    // elem_q selects M1..M4: bit 1 = descending, bit 0 = element reads ~B
    logic [1:0]    elem_q, elem_d;
    logic [15:0]   bg;
    logic [15:0]   rd_exp;
    logic [15:0]   wr_val;

    // M5 compare pipeline: the read issued in M5_R is checked one cycle later
    logic          chk_pend_q;
    logic [AW-1:0] chk_addr_q;
    logic [15:0]   chk_exp_q;

    logic          mis;
    logic [AW-1:0] mis_addr;
    logic          start_ok;

`ifdef RAM_BIST_CHECKERBOARD_EN
    logic          pass_q, pass_d;
    assign bg = pass_q ? 16'h5555 : 16'h0000;
`else
    assign bg = 16'h0000;
`endif

    assign rd_exp    = elem_q[0] ? ~bg : bg;
    assign wr_val    = elem_q[0] ? bg : ~bg;
    assign start_ok  = (state_q == S_IDLE) && bist_start;
    assign bist_busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bist_done = (state_q == S_DONE);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            elem_q     <= 2'd0;
            chk_pend_q <= 1'b0;
            chk_addr_q <= '0;
            chk_exp_q  <= 16'h0000;
`ifdef RAM_BIST_CHECKERBOARD_EN
            pass_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            elem_q     <= elem_d;
            chk_pend_q <= (state_q == S_M5_R);
            chk_addr_q <= addr_q;
            chk_exp_q  <= bg;
`ifdef RAM_BIST_CHECKERBOARD_EN
            pass_q     <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        elem_d       = elem_q;
`ifdef RAM_BIST_CHECKERBOARD_EN
        pass_d       = pass_q;
`endif
        ram.ram_en   = 1'b0;
        ram.ram_we   = 2'b00;
        ram.ram_addr = '0;
        ram.ram_din  = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (bist_start) begin
                    state_d = S_M0_W;
                    addr_d  = '0;
`ifdef RAM_BIST_CHECKERBOARD_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            S_M0_W: begin
                ram.ram_en   = 1'b1;
                ram.ram_we   = 2'b11;
                ram.ram_addr = addr_q;
                ram.ram_din  = bg;
                if (addr_q == LAST) begin
                    state_d = S_M_R;
                    elem_d  = 2'd0;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + AW'(1);
                end
            end
            S_M_R: begin
                ram.ram_en   = 1'b1;
                ram.ram_addr = addr_q;
                state_d      = S_M_W;
            end
            S_M_W: begin
                ram.ram_en   = 1'b1;
                ram.ram_we   = 2'b11;
                ram.ram_addr = addr_q;
                ram.ram_din  = wr_val;
                state_d      = S_M_R;
                if (elem_q[1] ? (addr_q == '0) : (addr_q == LAST)) begin
                    // element finished: reload the counter for the next one
                    case (elem_q)
                        2'd0: begin elem_d = 2'd1; addr_d = '0;   end
                        2'd1: begin elem_d = 2'd2; addr_d = LAST; end
                        2'd2: begin elem_d = 2'd3; addr_d = LAST; end
                        default: begin state_d = S_M5_R; addr_d = '0; end
                    endcase
                end else if (elem_q[1]) begin
                    addr_d = addr_q - AW'(1);
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_M5_R: begin
                ram.ram_en   = 1'b1;
                ram.ram_addr = addr_q;
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
`ifdef RAM_BIST_CHECKERBOARD_EN
                if (!pass_q) begin
                    state_d = S_M0_W;
                    pass_d  = 1'b1;
                    addr_d  = '0;
                end else begin
                    state_d = S_DONE;
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // M_W sees the data read in the preceding M_R; M5 reads are checked a cycle late
    always_comb begin
        mis      = 1'b0;
        mis_addr = addr_q;
        if ((state_q == S_M_W) && (ram.ram_dout != rd_exp)) begin
            mis = 1'b1;
        end else if (chk_pend_q && (ram.ram_dout != chk_exp_q)) begin
            mis      = 1'b1;
            mis_addr = chk_addr_q;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
            bist_fail_data <= 16'h0000;
        end else if (start_ok) begin
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
            bist_fail_data <= 16'h0000;
        end else if (mis && !bist_fail) begin
            bist_fail      <= 1'b1;
            bist_fail_addr <= mis_addr;
            bist_fail_data <= ram.ram_dout;
        end
    end
endmodule
